// File: rtl/fp_normalize_pipe.sv
// Two-stage post-add normaliser: S1 captures the raw sum and its leading-zero count,
// S2 applies the shift and exponent adjustment and flags overflow or flush-to-zero.
module fp_normalize_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAN_W+1:0] in_man,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAN_W:0]   out_man,
    output logic [EXP_W-1:0] out_exp,
    output logic [1:0]       out_exc,
    output logic             out_sticky
);
    localparam int LZW = $clog2(MAN_W + 2);
    localparam int EW  = EXP_W + 1;
    localparam logic [EW-1:0] EXP_MAXF = EW'((2 ** EXP_W) - 2);

    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_OVF  = 2'b01;
    localparam logic [1:0] EXC_UNF  = 2'b10;

    typedef struct packed {
        logic [MAN_W+1:0] man;
        logic [EXP_W-1:0] exp;
        logic             carry;
        logic [LZW-1:0]   lz;
    } s1_t;

    typedef struct packed {
        logic [MAN_W:0]   man;
        logic [EXP_W-1:0] exp;
        logic [1:0]       exc;
        logic             sticky;
    } res_t;

    logic [2:1] vld_pipe;
    logic       adv1, adv2;
    logic [LZW-1:0] lz;
    s1_t  s1_q;
    res_t res_d, res_q;
    logic [EW-1:0] e_inc, e_sub;

    assign adv2     = !vld_pipe[2] || out_ready;
    assign adv1     = !vld_pipe[1] || adv2;
    assign in_ready = adv1;

    // Ascending scan: the highest set bit writes last, so lz counts from the hidden position.
    always_comb begin
        lz = LZW'(MAN_W + 1);
        for (int i = 0; i <= MAN_W; i++) begin
            if (in_man[i]) lz = LZW'(MAN_W - i);
        end
    end

    always_comb begin
        res_d = '0;
        e_inc = EW'(s1_q.exp) + EW'(1);
        e_sub = EW'(s1_q.exp) - EW'(s1_q.lz);
        if (&s1_q.exp) begin
            res_d.exp = '1;
            res_d.exc = EXC_OVF;
        end else if (s1_q.carry) begin
            if (e_inc > EXP_MAXF) begin
                res_d.exp = '1;
                res_d.exc = EXC_OVF;
            end else begin
                res_d.man    = s1_q.man[MAN_W+1:1];
                res_d.sticky = s1_q.man[0];
                res_d.exp    = e_inc[EXP_W-1:0];
                res_d.exc    = EXC_NONE;
            end
        end else if (s1_q.man == '0) begin
            res_d.exc = EXC_NONE;
        end else if (EW'(s1_q.exp) > EW'(s1_q.lz)) begin
            res_d.man = s1_q.man[MAN_W:0] << s1_q.lz;
            res_d.exp = e_sub[EXP_W-1:0];
        end else begin
            // No denormal support: a result below the smallest normal flushes to zero.
            res_d.exc = EXC_UNF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            res_q    <= '0;
        end else begin
            if (adv1) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) begin
                    s1_q.man   <= in_man;
                    s1_q.exp   <= in_exp;
                    s1_q.carry <= in_man[MAN_W+1];
                    s1_q.lz    <= lz;
                end
            end
            if (adv2) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) res_q <= res_d;
            end
        end
    end

    assign out_valid  = vld_pipe[2];
    assign out_man    = res_q.man;
    assign out_exp    = res_q.exp;
    assign out_exc    = res_q.exc;
    assign out_sticky = res_q.sticky;
endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Scoreboard bench for fp_normalize_pipe: directed vectors push expectations,
// an independent monitor pops and compares on every output handshake.
module tb_fp_normalize_pipe;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;

    typedef struct packed {
        logic [MAN_W:0]   man;
        logic [EXP_W-1:0] exp;
        logic [1:0]       exc;
        logic             sticky;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [MAN_W+1:0] in_man;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic [MAN_W:0]   out_man;
    logic [EXP_W-1:0] out_exp;
    logic [1:0]       out_exc;
    logic             out_sticky;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pushed = 0;
    int   n_discarded = 0;
    int   n_out    = 0;
    exp_t sb[$];

    fp_normalize_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_man(in_man), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready), .out_man(out_man),
        .out_exp(out_exp), .out_exc(out_exc), .out_sticky(out_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drives one beat; returns the number of cycles in_ready held it off.
    task automatic send(input logic [MAN_W+1:0] m, input logic [EXP_W-1:0] e,
                        input logic [MAN_W:0] xm, input logic [EXP_W-1:0] xe,
                        input logic [1:0] xc, input logic xs, output int waits);
        exp_t x;
        bit   done = 0;
        x = '{man: xm, exp: xe, exc: xc, sticky: xs};
        waits = 0;
        in_valid = 1'b1;
        in_man   = m;
        in_exp   = e;
        while (!done && waits < 200) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(x);
                n_pushed++;
                done = 1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 32'(waits), 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: compares on handshake, and checks outputs hold while stalled.
    initial begin : monitor
        exp_t x;
        exp_t prev;
        bit   hold = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 0;
            end else begin
                if (hold) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data", 32'({out_man, out_exp, out_exc, out_sticky}), 32'(prev));
                end
                if (out_valid && out_ready) begin
                    n_out++;
                    if (sb.size() == 0) begin
                        chk("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        x = sb.pop_front();
                        chk("out_man", 32'(out_man), 32'(x.man));
                        chk("out_exp", 32'(out_exp), 32'(x.exp));
                        chk("out_exc", 32'(out_exc), 32'(x.exc));
                        chk("out_sticky", 32'(out_sticky), 32'(x.sticky));
                    end
                end
                hold = out_valid && !out_ready;
                prev = '{man: out_man, exp: out_exp, exc: out_exc, sticky: out_sticky};
            end
        end
    end

    // Directed vectors: {in_man, in_exp, exp_man, exp_exp, exp_exc, exp_sticky}
    typedef struct {
        logic [MAN_W+1:0] m;
        logic [EXP_W-1:0] e;
        logic [MAN_W:0]   xm;
        logic [EXP_W-1:0] xe;
        logic [1:0]       xc;
        logic             xs;
    } vec_t;

    vec_t vecs[$] = '{
        '{12'hC01, 5'd15, 11'h600, 5'd16, 2'b00, 1'b1},  // carry with sticky
        '{12'h800, 5'd30, 11'h000, 5'd31, 2'b01, 1'b0},  // carry overflows
        '{12'h555, 5'd31, 11'h000, 5'd31, 2'b01, 1'b0},  // inf input
        '{12'hC00, 5'd31, 11'h000, 5'd31, 2'b01, 1'b0},  // inf input beats carry
        '{12'h010, 5'd10, 11'h400, 5'd4,  2'b00, 1'b0},  // left shift 6
        '{12'h010, 5'd6,  11'h000, 5'd0,  2'b10, 1'b0},  // exp == lz flushes
        '{12'h000, 5'd20, 11'h000, 5'd0,  2'b00, 1'b0},  // exact zero
        '{12'h800, 5'd29, 11'h400, 5'd30, 2'b00, 1'b0},  // carry to max finite
        '{12'hFFF, 5'd0,  11'h7FF, 5'd1,  2'b00, 1'b1},  // carry from exp 0
        '{12'h7FF, 5'd1,  11'h7FF, 5'd1,  2'b00, 1'b0},  // already normal, lz=0
        '{12'h400, 5'd0,  11'h000, 5'd0,  2'b10, 1'b0},  // exp 0, lz 0 flushes
        '{12'h001, 5'd11, 11'h400, 5'd1,  2'b00, 1'b0},  // max shift 10
        '{12'h001, 5'd10, 11'h000, 5'd0,  2'b10, 1'b0}   // max shift underflows
    };

    initial begin : stim
        int w;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_man    = '0;
        in_exp    = '0;
        out_ready = 1'b1;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'({out_man, out_exp, out_exc, out_sticky}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Identity plus two-cycle latency
        send(12'h400, 5'd15, 11'h400, 5'd15, 2'b00, 1'b0, w);
        chk("lat_s1_only", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_two_cycles", 32'(out_valid), 32'd1);
        drain();

        // Back-to-back at full throughput
        foreach (vecs[i]) begin
            send(vecs[i].m, vecs[i].e, vecs[i].xm, vecs[i].xe, vecs[i].xc, vecs[i].xs, w);
            chk("throughput_wait", 32'(w), 32'd0);
        end
        drain();

        // Backpressure: 4 beats, output stalled for 3 cycles
        out_ready = 1'b0;
        send(12'h400, 5'd15, 11'h400, 5'd15, 2'b00, 1'b0, w);
        send(12'hC01, 5'd15, 11'h600, 5'd16, 2'b00, 1'b1, w);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        fork
            begin
                send(12'h010, 5'd10, 11'h400, 5'd4, 2'b00, 1'b0, w);
                send(12'h000, 5'd20, 11'h000, 5'd0, 2'b00, 1'b0, w);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("bp_out_valid_held", 32'(out_valid), 32'd1);
                chk("bp_still_full", 32'(in_ready), 32'd0);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset while stalled with both stages full
        out_ready = 1'b0;
        send(12'h400, 5'd15, 11'h400, 5'd15, 2'b00, 1'b0, w);
        send(12'h7FF, 5'd1, 11'h7FF, 5'd1, 2'b00, 1'b0, w);
        chk("stall_full", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        n_discarded += sb.size();
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_stale_beat", 32'(out_valid), 32'd0);
        chk("beat_count", 32'(n_out), 32'(n_pushed - n_discarded));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
